mem_responder: RTL and testbench
================================

# mem_responder

On-chip memory target for the picorv32 native memory bus: it answers `mem_valid`/`mem_ready` requests from the CPU. It sits beside the CPU inside the top level, on the buffered global clock. Storage is a byte-writable synchronous block RAM. Response latency is programmable through a wait-state counter, and out-of-range accesses are flagged with a fault pulse.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; must be a power of 2.
- `BASE_ADDR`, default 32'h0000_0000: byte base address; must be aligned to 4*DEPTH_WORDS.
- `WAIT_STATES`, default 0: extra cycles inserted before the access; legal range 0..15.
- `ROM_WORDS`, default 256: number of write-protected words counted from the base; used only with `MEM_RESPONDER_WP_EN`.
- `clk` in 1: single clock, the global buffered clock.
- `reset` in 1: synchronous, active-high reset.
- `mem_valid` in 1: request from the CPU.
- `mem_instr` in 1: instruction fetch flag; informational only, ignored by the block.
- `mem_addr` in 32: byte address; bits [1:0] are ignored.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte write enables; 0 means read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data; valid only while `mem_ready`=1.
- `fault` out 1: one-cycle pulse coincident with `mem_ready` on a rejected access.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP, RECOVER.
- IDLE: when `mem_valid`=1, latch `mem_addr`, `mem_wdata` and `mem_wstrb`, and decode the address.
  - Next state is WAIT if WAIT_STATES>0, otherwise ACCESS.
  - Input changes after the latch are ignored for the rest of the transaction.
- WAIT: 4-bit counter loads WAIT_STATES-1 on entry and decrements; leave for ACCESS when it reaches 0.
- ACCESS: a single RAM operation.
  - Word index = (addr - BASE_ADDR) >> 2.
  - Write when wstrb≠0, applying per-byte enables.
  - Read when wstrb=0.
  - Rejected accesses touch no RAM.
- RESP: `mem_ready`=1.
  - Reads: `mem_rdata` = RAM output.
  - Writes and rejected accesses: `mem_rdata` = 0.
  - `fault`=1 if rejected.
  - Next state is RECOVER.
- RECOVER: `mem_valid` is ignored for exactly one cycle, then return to IDLE. This covers the CPU's registered deassertion of `mem_valid`.
- Rejected access: address < BASE_ADDR, or address ≥ BASE_ADDR + 4*DEPTH_WORDS.
- Protocol violation: if `mem_valid` drops before `mem_ready`, the transaction still completes normally.

## Timing
- Request first sampled in IDLE at cycle T: `mem_ready` is high at T+2+WAIT_STATES, for exactly 1 cycle.
- Reads and writes have identical latency.
- Minimum spacing between two ready pulses: 4 cycles (WAIT_STATES=0).
- Reset values: `mem_ready`=0, `fault`=0, `mem_rdata`=0, FSM=IDLE, counter=0.
- Outside RESP, `mem_ready`, `fault` and `mem_rdata` are all 0.
- Reset in any state returns the FSM to IDLE on the next edge. RAM contents are retained, and a pending write that has not reached ACCESS is dropped.
- A write performed in ACCESS is visible to a read whose ACCESS occurs in any later cycle.

## Configuration
- `MEM_RESPONDER_WP_EN` defined:
  - Writes to word index < ROM_WORDS are rejected: RAM unchanged, `fault`=1 with `mem_ready`, normal latency.
  - Reads of those words are unaffected.
- Undefined: all in-range words are writable, and ROM_WORDS is unused.

## Structure
- Package `mem_responder_pkg`:
  - FSM state enum.
  - Wait-counter width constant (4).
  - Fault read-data constant (32'h0).
- Sub-module `mem_responder_ram`:
  - Single-port synchronous RAM, DEPTH_WORDS x 32, 4 byte enables, registered read.
  - Must infer as block RAM.
- Top FSM, decode, wait counter and write-protect logic live in `mem_responder`.

## Test plan
- WAIT_STATES=0, write 0xA5A5_1234 to 0x10 with wstrb=4'b1111 -> ready at T+2 with fault=0. Then read 0x10 -> rdata=0xA5A5_1234.
- Preload 0x1122_3344 at 0x20, write 0x0000_00FF with wstrb=4'b0001 -> subsequent read of 0x20 returns 0x1122_33FF.
- WAIT_STATES=3, read request held until ready -> ready high only at T+5, for one cycle. `mem_valid` held high through RECOVER produces no second ready.
- Read BASE_ADDR + 4*DEPTH_WORDS -> ready at T+2, fault=1, rdata=0, and no RAM word changes.
- Assert reset at T+1 during a WAIT_STATES=3 write -> no ready. Target word is unchanged; the next request completes with normal latency.
- With `MEM_RESPONDER_WP_EN`, write 0xDEAD_BEEF to word 5 -> fault=1 and the word is unchanged. Without the macro, the same write succeeds with fault=0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder picorv32 memory target.
package mem_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP,
    ST_RECOVER
  } state_t;

  localparam int unsigned CNT_W       = 4;
  localparam logic [31:0] FAULT_RDATA = 32'h0;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port DEPTH_WORDS x 32 block RAM with byte enables and registered read.
module mem_responder_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read-first port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// picorv32 native-bus memory target with programmable wait states and fault pulse.
// Optional write protection of the low ROM_WORDS words: define MEM_RESPONDER_WP_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ROM_WORDS   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t             st;
  logic [CNT_W-1:0]   cnt;
  logic [AW-1:0]      idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic               reject_q;
  logic               rd_valid;
  logic [31:0]        ram_rdata;
  logic               ram_en;
  logic [3:0]         ram_we;

  logic [AW-1:0]      idx_c;
  logic               in_range_c;
  logic               wp_hit_c;
  logic               reject_c;
  logic               unused_ok;

  // Base is aligned to the window size, so range check is an upper-bit match.
  assign idx_c      = mem_addr[AW+1:2];
  assign in_range_c = (mem_addr[31:AW+2] == BASE_ADDR[31:AW+2]);

`ifdef MEM_RESPONDER_WP_EN
  assign wp_hit_c = (|mem_wstrb) && (32'(idx_c) < ROM_WORDS);
`else
  assign wp_hit_c = 1'b0;
`endif

  assign reject_c  = !in_range_c || wp_hit_c;
  assign unused_ok = ^{mem_instr, mem_addr[1:0], 32'(ROM_WORDS)};

  // A cycle with reset asserted never touches the array.
  assign ram_en    = (st == ST_ACCESS) && !reject_q && !reset;
  assign ram_we    = ram_en ? wstrb_q : 4'b0000;
  assign mem_rdata = rd_valid ? ram_rdata : FAULT_RDATA;

  mem_responder_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Transaction sequencer: latch, optional wait, access, respond, recover.
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      reject_q  <= 1'b0;
      mem_ready <= 1'b0;
      fault     <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      fault     <= 1'b0;
      rd_valid  <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (mem_valid) begin
            idx_q    <= idx_c;
            wdata_q  <= mem_wdata;
            wstrb_q  <= mem_wstrb;
            reject_q <= reject_c;
            if (WAIT_STATES > 0) begin
              cnt <= CNT_W'(WAIT_STATES - 1);
              st  <= ST_WAIT;
            end else begin
              st  <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) st <= ST_ACCESS;
          else           cnt <= cnt - 1'b1;
        end
        ST_ACCESS: begin
          mem_ready <= 1'b1;
          fault     <= reject_q;
          rd_valid  <= !reject_q && (wstrb_q == 4'b0000);
          st        <= ST_RESP;
        end
        ST_RESP:    st <= ST_RECOVER;
        ST_RECOVER: st <= ST_IDLE;
        default:    st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a zero-wait and a three-wait instance checked
// every cycle against a transaction-level model, plus literal expectations.
module tb_mem_responder;

  localparam int     DEPTH = 1024;
  localparam longint BASE  = 0;
  localparam int     ROM   = 256;
`ifdef MEM_RESPONDER_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  // Data tests move above the protected region when write protection is on.
  localparam logic [31:0] DOFS = WP ? 32'h400 : 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid [2];
  logic        instr [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        ready [2];
  logic        fault [2];
  logic [31:0] rdata [2];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0), .ROM_WORDS(256)) u_ws0 (
    .clk(clk), .reset(reset), .mem_valid(valid[0]), .mem_instr(instr[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_ready(ready[0]), .mem_rdata(rdata[0]),
    .fault(fault[0]));

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3), .ROM_WORDS(256)) u_ws3 (
    .clk(clk), .reset(reset), .mem_valid(valid[1]), .mem_instr(instr[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_ready(ready[1]), .mem_rdata(rdata[1]),
    .fault(fault[1]));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Transaction-level model state
  int          next_ok [2];
  bit          pend    [2];
  int          p_edge  [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_data  [2];
  logic [3:0]  p_strb  [2];
  logic [31:0] mm      [2][DEPTH];
  bit          known   [2][DEPTH];
  logic        e_ready [2];
  logic        e_fault [2];
  logic [31:0] e_rdata [2];
  bit          e_known [2];
  int          mw;

  function automatic int ws(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic bit rejected(input logic [31:0] a, input logic [3:0] s);
    longint la;
    la = longint'(a);
    if (la < BASE || la >= BASE + 4 * DEPTH) return 1'b1;
    if (WP && s != 4'b0000 && ((la - BASE) >> 2) < ROM) return 1'b1;
    return 1'b0;
  endfunction

  // Request accepted on edge e responds on edge e+1+ws and frees the target at e+4+ws.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      e_ready[i] = 1'b0;
      e_fault[i] = 1'b0;
      e_rdata[i] = 32'h0;
      e_known[i] = 1'b1;
      if (reset) begin
        pend[i]    = 1'b0;
        next_ok[i] = cyc + 1;
      end else begin
        if (pend[i] && cyc == p_edge[i]) begin
          pend[i]    = 1'b0;
          e_ready[i] = 1'b1;
          e_fault[i] = rejected(p_addr[i], p_strb[i]);
          if (!e_fault[i]) begin
            mw = int'((longint'(p_addr[i]) - BASE) >> 2);
            if (p_strb[i] == 4'b0000) begin
              e_rdata[i] = mm[i][mw];
              e_known[i] = known[i][mw];
            end else begin
              for (int b = 0; b < 4; b++)
                if (p_strb[i][b]) mm[i][mw][8*b +: 8] = p_data[i][8*b +: 8];
              if (p_strb[i] == 4'hF) known[i][mw] = 1'b1;
            end
          end
        end
        if (!pend[i] && cyc >= next_ok[i] && valid[i]) begin
          pend[i]    = 1'b1;
          p_edge[i]  = cyc + 1 + ws(i);
          next_ok[i] = cyc + 4 + ws(i);
          p_addr[i]  = addr[i];
          p_data[i]  = wdata[i];
          p_strb[i]  = wstrb[i];
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (ready[i] !== e_ready[i]) begin
          n_err++;
          $display("FAIL ready[%0d] cyc %0d: got %b expected %b", i, cyc, ready[i], e_ready[i]);
        end
        n_vec++;
        if (fault[i] !== e_fault[i]) begin
          n_err++;
          $display("FAIL fault[%0d] cyc %0d: got %b expected %b", i, cyc, fault[i], e_fault[i]);
        end
        if (e_known[i]) begin
          n_vec++;
          if (rdata[i] !== e_rdata[i]) begin
            n_err++;
            $display("FAIL rdata[%0d] cyc %0d: got %h expected %h", i, cyc, rdata[i], e_rdata[i]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus transaction; hold=0 drops valid and scrambles inputs right after the latch.
  task automatic xact(input int i, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit hold,
                      output int lat, output logic [31:0] rd, output logic flt);
    int c0;
    bit got;
    got = 1'b0; lat = 0; rd = 32'h0; flt = 1'b0;
    @(negedge clk); #1;
    valid[i] = 1'b1; addr[i] = a; wdata[i] = d; wstrb[i] = s;
    c0 = cyc;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk); #1;
      if (!hold) begin
        valid[i] = 1'b0; addr[i] = 32'hFFFF_FFF0; wdata[i] = 32'hFFFF_FFFF; wstrb[i] = 4'hF;
      end
      if (ready[i] === 1'b1) begin
        got = 1'b1; lat = cyc - c0; rd = rdata[i]; flt = fault[i];
      end
    end
    chk("ready seen", 32'(got), 32'h1);
    repeat (2) @(negedge clk);
    #1;
    valid[i] = 1'b0;
  endtask

  task automatic quiet(input int i, input int n);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      if (ready[i] !== 1'b0) seen = 1'b1;
    end
    chk("no extra ready", 32'(seen), 32'h0);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        flt;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; instr[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0; wstrb[i] = 4'h0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset ready", 32'(ready[0]), 32'h0);
    chk("reset fault", 32'(fault[0]), 32'h0);
    chk("reset rdata", rdata[1], 32'h0);
    reset = 1'b0;

    xact(0, 32'h10 + DOFS, 32'hA5A5_1234, 4'hF, 1'b1, lat, rd, flt);
    chk("wr lat", 32'(lat), 32'd2);
    chk("wr fault", 32'(flt), 32'h0);
    chk("wr rdata", rd, 32'h0);
    xact(0, 32'h10 + DOFS, 32'h0, 4'h0, 1'b1, lat, rd, flt);
    chk("rd lat", 32'(lat), 32'd2);
    chk("rd data", rd, 32'hA5A5_1234);

    xact(0, 32'h20 + DOFS, 32'h1122_3344, 4'hF, 1'b1, lat, rd, flt);
    xact(0, 32'h20 + DOFS, 32'h0000_00FF, 4'b0001, 1'b1, lat, rd, flt);
    xact(0, 32'h20 + DOFS, 32'h0, 4'h0, 1'b1, lat, rd, flt);
    chk("byte merge", rd, 32'h1122_33FF);

    xact(0, 32'h40 + DOFS, 32'h0BAD_F00D, 4'hF, 1'b0, lat, rd, flt);
    chk("early drop lat", 32'(lat), 32'd2);
    xact(0, 32'h40 + DOFS, 32'h0, 4'h0, 1'b1, lat, rd, flt);
    chk("early drop data", rd, 32'h0BAD_F00D);

    xact(0, 32'h0000_1000, 32'h0, 4'h0, 1'b1, lat, rd, flt);
    chk("oor lat", 32'(lat), 32'd2);
    chk("oor fault", 32'(flt), 32'h1);
    chk("oor rdata", rd, 32'h0);
    xact(0, 32'h0000_1000 + 32'h10 + DOFS, 32'hFFFF_FFFF, 4'hF, 1'b1, lat, rd, flt);
    chk("oor wr fault", 32'(flt), 32'h1);
    xact(0, 32'h10 + DOFS, 32'h0, 4'h0, 1'b1, lat, rd, flt);
    chk("alias intact", rd, 32'hA5A5_1234);
    xact(0, 32'h0000_0FFC, 32'h600D_CAFE, 4'hF, 1'b1, lat, rd, flt);
    chk("top word fault", 32'(flt), 32'h0);
    xact(0, 32'h0000_0FFC, 32'h0, 4'h0, 1'b1, lat, rd, flt);
    chk("top word data", rd, 32'h600D_CAFE);

    xact(0, 32'h14, 32'hDEAD_BEEF, 4'hF, 1'b1, lat, rd, flt);
    chk("word5 wr fault", 32'(flt), 32'(WP));
    xact(0, 32'h14, 32'h0, 4'h0, 1'b1, lat, rd, flt);
    chk("word5 rd fault", 32'(flt), 32'h0);
`ifndef MEM_RESPONDER_WP_EN
    chk("word5 data", rd, 32'hDEAD_BEEF);
`endif

    xact(1, 32'h30 + DOFS, 32'h1357_9BDF, 4'hF, 1'b1, lat, rd, flt);
    chk("ws3 wr lat", 32'(lat), 32'd5);
    xact(1, 32'h30 + DOFS, 32'h0, 4'h0, 1'b1, lat, rd, flt);
    chk("ws3 rd lat", 32'(lat), 32'd5);
    chk("ws3 rd data", rd, 32'h1357_9BDF);
    quiet(1, 6);

    // Reset lands during the first wait cycle of a write
    @(negedge clk); #1;
    valid[1] = 1'b1; addr[1] = 32'h30 + DOFS; wdata[1] = 32'h5555_AAAA; wstrb[1] = 4'hF;
    @(negedge clk); #1;
    valid[1] = 1'b0; wstrb[1] = 4'h0; reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    quiet(1, 8);
    xact(1, 32'h30 + DOFS, 32'h0, 4'h0, 1'b1, lat, rd, flt);
    chk("post reset lat", 32'(lat), 32'd5);
    chk("dropped write", rd, 32'h1357_9BDF);
    xact(0, 32'h10 + DOFS, 32'h0, 4'h0, 1'b1, lat, rd, flt);
    chk("retained data", rd, 32'hA5A5_1234);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
